// File: rtl/alu.sv
// Registered n-bit ALU: eight operations with overflow, zero and negative flags.
// The result and all three flags load together on a clock edge when en is high.
module alu #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [2:0]   op,
  input  logic         en,
  output logic [n-1:0] sum,
  output logic         o_flag,
  output logic         z_flag,
  output logic         n_flag
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  logic [n-1:0] r;
  logic         ovf;
  logic         r_zero;
  logic         r_neg;

  // Carry-out is intentionally dropped; arithmetic wraps modulo 2^n.
  always_comb begin
    r   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        r   = A + B;
        ovf = (A[n-1] == B[n-1]) && (r[n-1] != A[n-1]);
      end
      OP_SUB: begin
        r   = A - B;
        ovf = (A[n-1] != B[n-1]) && (r[n-1] != A[n-1]);
      end
      OP_AND: r = A & B;
      OP_OR:  r = A | B;
      OP_XOR: r = A ^ B;
      OP_NOT: r = ~A;
      OP_MOV: r = A;
      OP_CLR: r = '0;
      default: begin
        r   = '0;
        ovf = 1'b0;
      end
    endcase
  end

  assign r_zero = (r == '0);
  assign r_neg  = r[n-1];

  // Flags are derived from the same r that lands in sum, so they never disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum    <= '0;
      o_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else if (en) begin
      sum    <= r;
      o_flag <= ovf;
      z_flag <= r_zero;
      n_flag <= r_neg;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes hand-computed expectations,
// a monitor pops and compares them one cycle after issue.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic        en8;
  logic [7:0]  sum8;
  logic        o8, z8, n8;
  logic [15:0] a16, b16;
  logic [2:0]  op16;
  logic        en16;
  logic [15:0] sum16;
  logic        o16, z16, n16;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    logic        wide;
    logic [15:0] s;
    logic        o;
    logic        z;
    logic        n;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  alu #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .op(op8), .en(en8),
    .sum(sum8), .o_flag(o8), .z_flag(z8), .n_flag(n8)
  );

  alu #(.n(16)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .op(op16), .en(en16),
    .sum(sum16), .o_flag(o16), .z_flag(z16), .n_flag(n16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] as, input logic ao, az, an,
                     input logic [15:0] es, input logic eo, ez, en_exp);
    total++;
    if (as === es && ao === eo && az === ez && an === en_exp) passed++;
    else $display("FAIL %s: got sum=%h o=%b z=%b n=%b, want sum=%h o=%b z=%b n=%b",
                  name, as, ao, az, an, es, eo, ez, en_exp);
  endtask

  // Monitor: compare every expectation whose result edge has passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.wide) chk(e.name, sum16, o16, z16, n16, e.s, e.o, e.z, e.n);
        else        chk(e.name, {8'h00, sum8}, o8, z8, n8, e.s, e.o, e.z, e.n);
      end
    end
  end

  task automatic issue8(input string nm, input logic [7:0] a, b, input logic [2:0] o,
                        input logic e, input logic [7:0] es, input logic eo, ez, en_exp);
    exp_t x;
    @(negedge clk);
    a8 = a; b8 = b; op8 = o; en8 = e;
    x.wide = 1'b0; x.s = {8'h00, es}; x.o = eo; x.z = ez; x.n = en_exp;
    x.due = cyc + 1; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic issue16(input string nm, input logic [15:0] a, b, input logic [2:0] o,
                         input logic e, input logic [15:0] es, input logic eo, ez, en_exp);
    exp_t x;
    @(negedge clk);
    a16 = a; b16 = b; op16 = o; en16 = e;
    x.wide = 1'b1; x.s = es; x.o = eo; x.z = ez; x.n = en_exp;
    x.due = cyc + 1; x.name = nm;
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b0;
    a8 = '0; b8 = '0; op8 = '0; en8 = 1'b0;
    a16 = '0; b16 = '0; op16 = '0; en16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset8", {8'h00, sum8}, o8, z8, n8, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("reset16", sum16, o16, z16, n16, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Enable gating
    issue8("en0_hold_reset", 8'h01, 8'h89, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    issue8("en1_add",        8'h01, 8'h89, 3'b000, 1'b1, 8'h8A, 1'b0, 1'b0, 1'b1);
    issue8("en0_hold_a",     8'h55, 8'h22, 3'b000, 1'b0, 8'h8A, 1'b0, 1'b0, 1'b1);
    issue8("en0_hold_b",     8'h00, 8'h00, 3'b111, 1'b0, 8'h8A, 1'b0, 1'b0, 1'b1);

    // Add
    issue8("add_ovf",        8'h41, 8'h41, 3'b000, 1'b1, 8'h82, 1'b1, 1'b0, 1'b1);
    issue8("add_neg_noovf",  8'hC1, 8'hE1, 3'b000, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1);
    issue8("add_wrap_zero",  8'h01, 8'hFF, 3'b000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    // Subtract
    issue8("sub_zero",       8'h01, 8'h01, 3'b001, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    issue8("sub_noovf",      8'hFF, 8'h93, 3'b001, 1'b1, 8'h6C, 1'b0, 1'b0, 1'b0);
    issue8("sub_ovf",        8'h80, 8'h01, 3'b001, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);

    // Logic ops, back-to-back
    issue8("and",            8'h01, 8'h89, 3'b010, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    issue8("or",             8'h01, 8'h89, 3'b011, 1'b1, 8'h89, 1'b0, 1'b0, 1'b1);
    issue8("xor",            8'h01, 8'h89, 3'b100, 1'b1, 8'h88, 1'b0, 1'b0, 1'b1);
    issue8("not",            8'h01, 8'h89, 3'b101, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    issue8("mov",            8'h01, 8'h89, 3'b110, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    issue8("clr",            8'h01, 8'h89, 3'b111, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    issue8("add_after_clr",  8'h41, 8'h41, 3'b000, 1'b1, 8'h82, 1'b1, 1'b0, 1'b1);
    issue8("and_clears_ovf", 8'hF0, 8'h0F, 3'b010, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    // Async reset mid-cycle
    issue8("pre_reset_load", 8'h01, 8'h89, 3'b000, 1'b1, 8'h8A, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    en8 = 1'b0;
    #1 rst = 1'b0;
    #1 chk("async_reset", {8'h00, sum8}, o8, z8, n8, 16'h0000, 1'b0, 1'b0, 1'b0);
    issue8("reset_over_en",  8'h41, 8'h41, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    issue8("release_en0",    8'h41, 8'h41, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    issue8("first_load",     8'hC1, 8'hE1, 3'b000, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1);

    // Wide instance
    issue16("w16_add_ovf",   16'h7FFF, 16'h0001, 3'b000, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
    issue16("w16_sub_zero",  16'h1234, 16'h1234, 3'b001, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    en8 = 1'b0; en16 = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
